// File: rtl/icmp_rx_gate.sv
// rtl/icmp_rx_gate.sv - admits ICMP packets to the icmp block; echo rate limit
// (token bucket) is built only when ICMP_RATE_LIMIT_EN is defined.
module icmp_rx_gate #(
  parameter int TOKENS_MAX    = 4,
  parameter int REFILL_CYCLES = 125000,
  parameter int CNT_W         = 16
) (
  input  logic             rx_clock,
  input  logic             reset,
  input  logic             ip_rx_enable,
  input  logic [7:0]       ip_protocol,
  input  logic [7:0]       ip_rx_data,
  input  logic             icmp_busy,
  input  logic             dst_unreachable_in,
  output logic             icmp_rx_enable,
  output logic [7:0]       icmp_rx_data,
  output logic [3:0]       tokens,
  output logic [CNT_W-1:0] accept_count,
  output logic [CNT_W-1:0] drop_count,
  output logic [CNT_W-1:0] unreach_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_DROP} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [3:0]       TOKENS_FULL = 4'(TOKENS_MAX);

  state_t state, state_next;
  logic   prev_en;
  logic   start;
  logic   is_icmp;
  logic   is_echo;
  logic   is_unreach;
  logic   token_ok;
  logic   admit;
  logic   enable_next;
  logic   accept_inc;
  logic   drop_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && v != CNT_MAX) ? v + CNT_W'(1) : v;
  endfunction

  // prev_en resets high so a packet already in flight at reset release is not a start
  assign start      = ip_rx_enable & ~prev_en;
  assign is_icmp    = (ip_protocol == 8'd1);
  assign is_echo    = (ip_rx_data == 8'd8);
  assign is_unreach = (ip_rx_data == 8'd3);
  assign admit      = is_icmp & ~icmp_busy & ((is_echo & token_ok) | is_unreach);

  always_comb begin
    state_next  = state;
    enable_next = 1'b0;
    accept_inc  = 1'b0;
    drop_inc    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (admit) begin
            state_next  = ST_PASS;
            enable_next = 1'b1;
            accept_inc  = 1'b1;
          end else begin
            state_next = ST_DROP;
            drop_inc   = is_icmp;
          end
        end
      end
      ST_PASS: begin
        if (ip_rx_enable) begin
          enable_next = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (!ip_rx_enable) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge rx_clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      prev_en        <= 1'b1;
      icmp_rx_enable <= 1'b0;
      icmp_rx_data   <= 8'h00;
    end else begin
      state          <= state_next;
      prev_en        <= ip_rx_enable;
      icmp_rx_enable <= enable_next;
      icmp_rx_data   <= ip_rx_data;
    end
  end

  always_ff @(posedge rx_clock) begin
    if (reset) begin
      accept_count  <= '0;
      drop_count    <= '0;
      unreach_count <= '0;
    end else begin
      accept_count  <= sat_inc(accept_count, accept_inc);
      drop_count    <= sat_inc(drop_count, drop_inc);
      unreach_count <= sat_inc(unreach_count, dst_unreachable_in);
    end
  end

`ifdef ICMP_RATE_LIMIT_EN
  localparam int RW = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;

  logic [RW-1:0] refill_cnt;
  logic [3:0]    tokens_q;
  logic          tick;
  logic          consume;

  assign tick     = (refill_cnt == RW'(REFILL_CYCLES - 1));
  assign consume  = accept_inc & is_echo;
  assign token_ok = (tokens_q != 4'd0);
  assign tokens   = tokens_q;

  // a refill and a consume in the same cycle cancel out
  always_ff @(posedge rx_clock) begin
    if (reset) begin
      refill_cnt <= '0;
      tokens_q   <= TOKENS_FULL;
    end else begin
      refill_cnt <= tick ? '0 : refill_cnt + RW'(1);
      if (tick && !consume && tokens_q < TOKENS_FULL) begin
        tokens_q <= tokens_q + 4'd1;
      end else if (consume && !tick) begin
        tokens_q <= tokens_q - 4'd1;
      end
    end
  end
`else
  assign token_ok = 1'b1;
  assign tokens   = TOKENS_FULL;
`endif

endmodule

// File: tb/tb_icmp_rx_gate.sv
// tb/tb_icmp_rx_gate.sv - scoreboard bench for icmp_rx_gate (TOKENS_MAX=4,
// REFILL_CYCLES=100, CNT_W=4); expectations follow ICMP_RATE_LIMIT_EN.
module tb_icmp_rx_gate;

`ifdef ICMP_RATE_LIMIT_EN
  localparam bit RL = 1'b1;
`else
  localparam bit RL = 1'b0;
`endif

  logic       rx_clock = 1'b0;
  logic       reset;
  logic       ip_rx_enable;
  logic [7:0] ip_protocol;
  logic [7:0] ip_rx_data;
  logic       icmp_busy;
  logic       dst_unreachable_in;
  logic       icmp_rx_enable;
  logic [7:0] icmp_rx_data;
  logic [3:0] tokens;
  logic [3:0] accept_count;
  logic [3:0] drop_count;
  logic [3:0] unreach_count;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         rel_cyc  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  logic [7:0] pkt[0:31];

  icmp_rx_gate #(.TOKENS_MAX(4), .REFILL_CYCLES(100), .CNT_W(4)) dut (
    .rx_clock          (rx_clock),
    .reset             (reset),
    .ip_rx_enable      (ip_rx_enable),
    .ip_protocol       (ip_protocol),
    .ip_rx_data        (ip_rx_data),
    .icmp_busy         (icmp_busy),
    .dst_unreachable_in(dst_unreachable_in),
    .icmp_rx_enable    (icmp_rx_enable),
    .icmp_rx_data      (icmp_rx_data),
    .tokens            (tokens),
    .accept_count      (accept_count),
    .drop_count        (drop_count),
    .unreach_count     (unreach_count)
  );

  always #5 rx_clock = ~rx_clock;

  // edges since reset release; the refill tick lands on edge 100, 200, ...
  always @(posedge rx_clock) begin
    if (reset) rel_cyc <= 0;
    else       rel_cyc <= rel_cyc + 1;
  end

  always @(posedge rx_clock) begin
    #1;
    if (icmp_rx_enable) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL fwd_unexpected: enable=1 data=%02h, required enable=0", icmp_rx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (icmp_rx_data !== mon_exp) begin
          n_fail++;
          $display("FAIL fwd_data: got %02h, required %02h", icmp_rx_data, mon_exp);
        end
      end
    end else if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      mon_exp = exp_q.pop_front();
      $display("FAIL fwd_missing: enable=0, required enable=1 with data %02h", mon_exp);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge rx_clock);
    reset        = 1'b1;
    ip_rx_enable = 1'b0;
    repeat (2) @(negedge rx_clock);
    reset = 1'b0;
  endtask

  task automatic fill(input logic [7:0] first, input int len);
    pkt[0] = first;
    for (int i = 1; i < len; i++) pkt[i] = 8'(8'h30 + i * 3);
  endtask

  // busy is driven to busy_val on the type byte and inverted for the rest
  task automatic send(input logic [7:0] proto, input int len, input bit fwd,
                      input bit busy_val, input int gap);
    for (int i = 0; i < len; i++) begin
      @(negedge rx_clock);
      ip_rx_enable = 1'b1;
      ip_protocol  = proto;
      ip_rx_data   = pkt[i];
      icmp_busy    = (i == 0) ? busy_val : ~busy_val;
      if (fwd) exp_q.push_back(pkt[i]);
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge rx_clock);
      ip_rx_enable = 1'b0;
      icmp_busy    = 1'b0;
      ip_rx_data   = 8'h00;
    end
  endtask

  task automatic wait_rel(input int n);
    int b;
    b = 0;
    while (rel_cyc != n && b < 1000) begin
      @(negedge rx_clock);
      b++;
    end
    if (rel_cyc != n) chk("wait_rel_timeout", rel_cyc, n);
  endtask

  initial begin
    reset              = 1'b1;
    ip_rx_enable       = 1'b1;
    ip_protocol        = 8'd1;
    ip_rx_data         = 8'hA5;
    icmp_busy          = 1'b0;
    dst_unreachable_in = 1'b0;
    repeat (3) @(negedge rx_clock);
    chk("rst_enable", icmp_rx_enable, 0);
    chk("rst_data", icmp_rx_data, 0);
    chk("rst_tokens", tokens, 4);
    chk("rst_accept", accept_count, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_unreach", unreach_count, 0);

    // packet already in flight at release must not count as a start
    reset      = 1'b0;
    ip_rx_data = 8'h08;
    repeat (3) @(negedge rx_clock);
    ip_rx_enable = 1'b0;
    repeat (2) @(negedge rx_clock);
    chk("inflight_accept", accept_count, 0);
    chk("inflight_drop", drop_count, 0);

    // single ping
    pkt[0] = 8'h08; pkt[1] = 8'h00; pkt[2] = 8'h12;
    pkt[3] = 8'h34; pkt[4] = 8'hAA; pkt[5] = 8'hBB;
    send(8'd1, 6, 1'b1, 1'b0, 2);
    chk("ping_tokens", tokens, RL ? 3 : 4);
    chk("ping_accept", accept_count, 1);

    // burst of six pings
    do_reset();
    for (int p = 0; p < 6; p++) begin
      fill(8'h08, 10);
      send(8'd1, 10, RL ? (p < 4) : 1'b1, 1'b0, 2);
    end
    chk("burst_accept", accept_count, RL ? 4 : 6);
    chk("burst_drop", drop_count, RL ? 2 : 0);
    chk("burst_tokens", tokens, RL ? 0 : 4);
    repeat (100) @(negedge rx_clock);
    chk("refill_tokens", tokens, RL ? 1 : 4);

    // busy drop, then drain tokens and send an unreachable
    do_reset();
    fill(8'h08, 4);
    send(8'd1, 4, 1'b0, 1'b1, 2);
    chk("busy_drop", drop_count, 1);
    chk("busy_accept", accept_count, 0);
    for (int p = 0; p < 4; p++) send(8'd1, 4, 1'b1, 1'b0, 2);
    fill(8'h03, 4);
    send(8'd1, 4, 1'b1, 1'b0, 2);
    chk("unr_accept", accept_count, 5);
    chk("unr_tokens", tokens, RL ? 0 : 4);

    // non-ICMP and unsupported type
    fill(8'h08, 20);
    send(8'd17, 20, 1'b0, 1'b0, 2);
    chk("udp_accept", accept_count, 5);
    chk("udp_drop", drop_count, 1);
    fill(8'h0D, 5);
    send(8'd1, 5, 1'b0, 1'b0, 2);
    chk("type0d_drop", drop_count, 2);
    chk("type0d_accept", accept_count, 5);

    // reset asserted on byte 3, released on byte 5
    do_reset();
    fill(8'h08, 8);
    for (int i = 0; i < 8; i++) begin
      @(negedge rx_clock);
      ip_rx_enable = 1'b1;
      ip_protocol  = 8'd1;
      ip_rx_data   = pkt[i];
      icmp_busy    = 1'b0;
      reset        = (i == 2 || i == 3);
      if (i < 2) exp_q.push_back(pkt[i]);
    end
    @(negedge rx_clock);
    ip_rx_enable = 1'b0;
    @(negedge rx_clock);
    chk("rstmid_accept", accept_count, 0);
    fill(8'h08, 6);
    send(8'd1, 6, 1'b1, 1'b0, 2);
    chk("rstmid_next_accept", accept_count, 1);
    chk("rstmid_next_tokens", tokens, RL ? 3 : 4);

    // consume on the same edge as the refill tick
    do_reset();
    fill(8'h08, 4);
    send(8'd1, 4, 1'b1, 1'b0, 2);
    chk("tick_pre_tokens", tokens, RL ? 3 : 4);
    wait_rel(98);
    send(8'd1, 4, 1'b1, 1'b0, 2);
    chk("tick_consume_tokens", tokens, RL ? 3 : 4);
    chk("tick_consume_accept", accept_count, 2);
    wait_rel(205);
    chk("tick_refill_tokens", tokens, 4);

    // saturation
    for (int i = 0; i < 20; i++) begin
      @(negedge rx_clock);
      dst_unreachable_in = 1'b1;
      @(negedge rx_clock);
      dst_unreachable_in = 1'b0;
    end
    chk("unreach_sat", unreach_count, 15);
    fill(8'h03, 2);
    for (int p = 0; p < 16; p++) send(8'd1, 2, 1'b1, 1'b0, 1);
    chk("accept_sat", accept_count, 15);
    chk("sat_drop", drop_count, 0);

    repeat (3) @(negedge rx_clock);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icmp_rx_gate.md
# icmp_rx_gate

Receive-side admission controller between the IP receive parser and the `icmp` block, clocked in the rx domain. For each IP packet carrying protocol 1, it decides from the first payload byte (ICMP type) whether to forward the packet to `icmp` or discard it. The decision uses a token-bucket rate limit for echo requests and the `icmp` busy status. It also keeps saturating statistics for accepted, dropped and destination-unreachable events.

## Interface
- TOKENS_MAX, 4: bucket depth; maximum burst of echo requests admitted back-to-back (1..15).
- REFILL_CYCLES, 125000: rx_clock cycles per token refill (1 ms at 125 MHz); must be ≥ 2.
- CNT_W, 16: width of the statistics counters.

- rx_clock  in  1  receive clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- ip_rx_enable  in  1  high for every IP payload byte of one packet; low for at least 1 cycle between packets.
- ip_protocol  in  8  IP protocol field; stable while ip_rx_enable is high.
- ip_rx_data  in  8  payload byte, valid when ip_rx_enable is high.
- icmp_busy  in  1  high while `icmp` is not idle (reply pending or transmitting).
- dst_unreachable_in  in  1  1-cycle pulse from `icmp` on a port-1024 unreachable.
- icmp_rx_enable  out  1  gated enable to `icmp`; registered.
- icmp_rx_data  out  8  ip_rx_data delayed 1 cycle; registered.
- tokens  out  4  current bucket level.
- accept_count  out  CNT_W  packets forwarded, saturating.
- drop_count  out  CNT_W  protocol-1 packets refused, saturating.
- unreach_count  out  CNT_W  dst_unreachable_in pulses, saturating.

## Operation
- **States:** ST_IDLE, ST_PASS, ST_DROP.
- **Packet start:** the cycle where ip_rx_enable=1 and prev_en=0. prev_en is the registered ip_rx_enable and resets to 1, so a packet already in flight at reset release is never treated as a start.
- **Decision in ST_IDLE on a packet start:**
  - ip_protocol ≠ 1: go to ST_DROP; no counter changes.
  - Type 8 (echo request), icmp_busy=0, tokens>0: go to ST_PASS; consume 1 token; accept_count+1.
  - Type 3 (unreachable), icmp_busy=0: go to ST_PASS; no token consumed; accept_count+1.
  - Any other type, or icmp_busy=1, or type 8 with tokens=0: go to ST_DROP; drop_count+1.
- **ST_PASS:** forward bytes. When ip_rx_enable=0, return to ST_IDLE.
- **ST_DROP:** when ip_rx_enable=0, return to ST_IDLE.
- **Forwarding:** icmp_rx_enable_next = (ST_IDLE & start & accept) | (ST_PASS & ip_rx_enable). The first (type) byte is forwarded. icmp_rx_data is always the 1-cycle-delayed ip_rx_data.
- **Refill:**
  - refill_cnt counts 0..REFILL_CYCLES-1, then wraps; the wrap cycle is a refill tick.
  - On a tick, tokens increment, saturating at TOKENS_MAX.
  - If a tick and a consume happen in the same cycle, tokens are unchanged.
- **Statistics:**
  - Counters hold at 2^CNT_W-1.
  - unreach_count increments on every dst_unreachable_in=1 cycle, in any state.

## Timing
- Latency ip_rx_* to icmp_rx_* is exactly 1 cycle. The gated enable is contiguous, with no holes within a packet.
- The decision is combinational on the start cycle; tokens and counters update on the following edge.
- icmp_busy is sampled only on the start cycle. A change mid-packet does not affect the current packet.
- ip_rx_enable low for one cycle between packets gives icmp_rx_enable low for one cycle. That is sufficient for `icmp` to return to ST_IDLE.
- **Reset values:**
  - icmp_rx_enable=0, icmp_rx_data=0, state=ST_IDLE.
  - tokens=TOKENS_MAX, refill_cnt=0.
  - All counters=0, prev_en=1.
- **Reset mid-packet:** output drops low on the next edge. The remainder of that packet is ignored until ip_rx_enable goes low.

## Configuration
- ICMP_RATE_LIMIT_EN
  - **Defined:** the token bucket and refill counter are built as described.
  - **Undefined:** the bucket logic is removed. Echo requests are admitted whenever icmp_busy=0. tokens is tied to TOKENS_MAX. All other behaviour is identical.

## Test plan
- **Single ping:** protocol 1, bytes 08 00 12 34 AA BB, busy=0 -> icmp_rx_enable high for 6 cycles starting 1 cycle after the first byte, data identical; tokens 4→3; accept_count=1.
- **Burst limit (REFILL_CYCLES=100):** 6 pings of 10 bytes, 2-cycle gaps -> first 4 forwarded, last 2 fully suppressed; drop_count=2; tokens=0. After 100 idle cycles, tokens=1.
- **Busy / unreachable:**
  - Ping with icmp_busy=1 -> no enable; drop_count+1.
  - Type 03 packet with tokens=0, busy=0 -> forwarded; tokens still 0.
- **Non-ICMP and unsupported type:**
  - Protocol 17, 20 bytes -> no enable; counters unchanged.
  - Protocol 1, type 0D -> dropped; drop_count+1.
- **Reset mid-packet:** reset asserted at byte 3 of a forwarded ping, released at byte 5 -> icmp_rx_enable low from the edge after reset; the rest of the packet is not forwarded; the next packet is accepted normally.
- **Saturation and macro (CNT_W=4):**
  - 20 dst_unreachable_in pulses -> unreach_count=15.
  - Tick coincident with a consume -> tokens unchanged.
  - Rerun the burst test without ICMP_RATE_LIMIT_EN -> all 6 forwarded; tokens reads 4.
